axi_lite_csr_slave: RTL
=======================

AXI_LITE_CSR_SLAVE -- requirements
Module: axi_lite_csr_slave

Interface
REQ-001 SHALL have parameter CSR_REG_NUM, default 64, meaning the number of 32-bit CSR words (power of 2, at least 4).
REQ-002 SHALL have parameter ADDR_W, default log2(CSR_REG_NUM)+2, meaning the byte-address width.
REQ-003 SHALL have port clk  input  1  single clock; all logic on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-005 SHALL have ports S_AXI_AWVALID in 1, S_AXI_AWREADY out 1, S_AXI_AWADDR in ADDR_W, S_AXI_AWPROT in 3 (ignored).
REQ-006 SHALL have ports S_AXI_WDATA in 32, S_AXI_WSTRB in 4, S_AXI_WVALID in 1, S_AXI_WREADY out 1.
REQ-007 SHALL have ports S_AXI_BRESP out 2, S_AXI_BVALID out 1, S_AXI_BREADY in 1.
REQ-008 SHALL have ports S_AXI_ARVALID in 1, S_AXI_ARREADY out 1, S_AXI_ARADDR in ADDR_W, S_AXI_ARPROT in 3 (ignored).
REQ-009 SHALL have ports S_AXI_RDATA out 32, S_AXI_RRESP out 2, S_AXI_RVALID out 1, S_AXI_RREADY in 1.
REQ-010 SHALL have port start  output  1  one-cycle accelerator start pulse.
REQ-011 SHALL have port done  input  1  one-cycle accelerator completion pulse.
REQ-012 SHALL have port csr_cfg  output  32*(CSR_REG_NUM-2)  words 2..N-1 flattened, word k at bits [32*(k-2)+:32].

Function
REQ-013 SHALL use word index = ADDR[ADDR_W-1:2] and ignore ADDR[1:0].
REQ-014 SHALL have the map: word0 CTRL (bit0 START, write-1, reads 0); word1 STATUS (bit0 BUSY RO, bit1 DONE sticky, write-1-to-clear); words 2..N-1 R/W config.
REQ-015 SHALL keep AW and W each in a one-entry holding register; AWREADY = AW holder empty; WREADY = W holder empty; each holder captures independently on its VALID&READY.
REQ-016 SHALL commit a write in the cycle both holders are full and BVALID=0, applying byte lanes per WSTRB and clearing both holders; BVALID=1 the next cycle.
REQ-017 SHALL hold BVALID until BVALID&BREADY, and SHALL drive BRESP=2'b00 always.
REQ-018 SHALL drive ARREADY = !RVALID; on an AR handshake, RDATA is registered and RVALID=1 the next cycle, held stable until RVALID&RREADY.
REQ-019 SHALL drive RRESP=2'b00 and RDATA=0 for unmapped bits and for CTRL.
REQ-020 SHALL pulse start for exactly one cycle on a committed CTRL write with WSTRB[0]=1, WDATA[0]=1 and BUSY=0; such a write while BUSY=1 is ignored.
REQ-021 SHALL set BUSY on start and clear it on done; done while BUSY=0 still sets DONE.
REQ-022 SHALL let set win over clear when done and a DONE W1C write occur in the same cycle.
REQ-023 SHALL allow a read and a write to proceed concurrently; a same-cycle read of a word being committed returns the old value.

Reset
REQ-024 SHALL, while rst=1, clear the holders, BVALID, RVALID, RDATA, start, BUSY, DONE and all config words to 0, and drive AWREADY/WREADY/ARREADY to 0.
REQ-025 SHALL drive AWREADY/WREADY/ARREADY to 1 in the first cycle after rst falls.
REQ-026 SHALL abandon any in-flight transaction on reset mid-operation, with no response issued.

Configuration
REQ-027 SHALL, when CSR_IRQ_EN is defined, add output irq (1 bit) = DONE & IRQ_EN (STATUS bit2, R/W, reset 0), registered, asserted the cycle after DONE sets.
REQ-028 SHALL, when CSR_IRQ_EN is undefined, have no irq port, and STATUS bit2 reads 0 and ignores writes.

Structure
REQ-029 SHALL place CSR word indices, STATUS bit positions and the BRESP/RRESP OKAY constant in the shared CNN defines package.
REQ-030 SHALL use one sub-module, csr_wr_holder: a one-entry valid/data register instantiated once for AW and once for W.

Verification
REQ-031 SHALL cover: AW and W in the same cycle, addr 0x08, data 0xA5A5A5A5, strb 0xF -> BVALID 1 cycle later, csr_cfg[31:0]=0xA5A5A5A5, readback equal.
REQ-032 SHALL cover: W 3 cycles before AW to 0x0C, strb 0x2, data 0x0000BB00 -> only byte1 of word3 = 0xBB; BVALID held through 5 cycles of BREADY=0.
REQ-033 SHALL cover: CTRL write 0x1 -> start high exactly 1 cycle, STATUS=0x1; second CTRL write -> no start; done pulse -> STATUS=0x2.
REQ-034 SHALL cover: done coincident with a STATUS write 0x2 -> DONE remains 1; a later write 0x2 -> STATUS=0x0.
REQ-035 SHALL cover: AR to 0x08 with RREADY=0 for 4 cycles -> RDATA stable, ARREADY=0 until the R handshake.
REQ-036 SHALL cover: rst asserted with BVALID pending -> BVALID=0, config=0, no B response after release.

Source files
------------

// File: rtl/axi_lite_csr_slave_pkg.sv
// Shared CSR definitions for axi_lite_csr_slave: word indices, STATUS bit
// positions, the AXI OKAY response code, the W-channel beat payload and a
// byte-lane merge helper.
package axi_lite_csr_slave_pkg;

    localparam int unsigned CSR_DATA_W = 32;
    localparam int unsigned CSR_STRB_W = CSR_DATA_W / 8;

    // Word map
    localparam int unsigned CSR_CTRL_IDX     = 0;
    localparam int unsigned CSR_STATUS_IDX   = 1;
    localparam int unsigned CSR_CFG_BASE_IDX = 2;

    // CTRL / STATUS bit positions
    localparam int unsigned CTRL_START_BIT    = 0;
    localparam int unsigned STATUS_BUSY_BIT   = 0;
    localparam int unsigned STATUS_DONE_BIT   = 1;
    localparam int unsigned STATUS_IRQ_EN_BIT = 2;

    localparam logic [1:0] AXI_RESP_OKAY = 2'b00;

    // One captured W beat
    typedef struct packed {
        logic [CSR_DATA_W-1:0] data;
        logic [CSR_STRB_W-1:0] strb;
    } csr_wbeat_t;

    // Replace only the byte lanes whose strobe is set
    function automatic logic [CSR_DATA_W-1:0] apply_wstrb(
        input logic [CSR_DATA_W-1:0] old_word,
        input logic [CSR_DATA_W-1:0] new_word,
        input logic [CSR_STRB_W-1:0] strb
    );
        logic [CSR_DATA_W-1:0] merged;
        merged = old_word;
        for (int unsigned b = 0; b < CSR_STRB_W; b++) begin
            if (strb[b]) begin
                merged[8*b +: 8] = new_word[8*b +: 8];
            end
        end
        return merged;
    endfunction

endpackage

// File: rtl/axi_lite_csr_slave_holder.sv
// csr_wr_holder: one-entry valid/data register used to park an AW or W beat
// until the write can be committed.
// Ports:
//   clk, rst        - clock, synchronous active-high reset
//   in_valid/ready  - upstream handshake; in_ready is high while empty
//   in_data         - payload captured on in_valid & in_ready
//   clr             - drop the held entry (write committed)
//   out_valid/data  - held entry
module csr_wr_holder #(
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              clr,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data
);

    logic              valid_q, valid_d;
    logic              ready_q, ready_d;
    logic [DATA_W-1:0] data_q,  data_d;

    // Capture / clear; ready mirrors emptiness but is held low in reset
    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (clr) begin
            valid_d = 1'b0;
        end
        if (in_valid && ready_q) begin
            valid_d = 1'b1;
            data_d  = in_data;
        end
        ready_d = !valid_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            ready_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            ready_q <= ready_d;
            data_q  <= data_d;
        end
    end

    assign in_ready  = ready_q;
    assign out_valid = valid_q;
    assign out_data  = data_q;

endmodule

// File: rtl/axi_lite_csr_slave.sv
// axi_lite_csr_slave: AXI4-Lite CSR block for an accelerator.
//   word 0 CTRL   : bit0 START (write 1 pulses start when idle, reads 0)
//   word 1 STATUS : bit0 BUSY (RO), bit1 DONE (sticky, W1C), bit2 IRQ_EN
//   words 2..N-1  : R/W configuration, exported flat on csr_cfg
// Ports: clk, rst (sync, active-high); AXI-Lite AW/W/B/AR/R slave channels;
//   start (1-cycle pulse out), done (1-cycle pulse in), csr_cfg, and irq
//   when built with CSR_IRQ_EN defined (irq = DONE & IRQ_EN, registered).
module axi_lite_csr_slave
    import axi_lite_csr_slave_pkg::*;
#(
    parameter int unsigned CSR_REG_NUM = 64,
    parameter int unsigned ADDR_W      = $clog2(CSR_REG_NUM) + 2
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          S_AXI_AWVALID,
    output logic                          S_AXI_AWREADY,
    input  logic [ADDR_W-1:0]             S_AXI_AWADDR,
    input  logic [2:0]                    S_AXI_AWPROT,
    input  logic [31:0]                   S_AXI_WDATA,
    input  logic [3:0]                    S_AXI_WSTRB,
    input  logic                          S_AXI_WVALID,
    output logic                          S_AXI_WREADY,
    output logic [1:0]                    S_AXI_BRESP,
    output logic                          S_AXI_BVALID,
    input  logic                          S_AXI_BREADY,
    input  logic                          S_AXI_ARVALID,
    output logic                          S_AXI_ARREADY,
    input  logic [ADDR_W-1:0]             S_AXI_ARADDR,
    input  logic [2:0]                    S_AXI_ARPROT,
    output logic [31:0]                   S_AXI_RDATA,
    output logic [1:0]                    S_AXI_RRESP,
    output logic                          S_AXI_RVALID,
    input  logic                          S_AXI_RREADY,
`ifdef CSR_IRQ_EN
    output logic                          irq,
`endif
    output logic                          start,
    input  logic                          done,
    output logic [32*(CSR_REG_NUM-2)-1:0] csr_cfg
);

    localparam int unsigned IDX_W   = ADDR_W - 2;
    localparam int unsigned CFG_NUM = CSR_REG_NUM - CSR_CFG_BASE_IDX;
    localparam int unsigned CFG_W   = CSR_DATA_W * CFG_NUM;
    localparam int unsigned WBEAT_W = $bits(csr_wbeat_t);

    logic [IDX_W-1:0] aw_idx;
    logic [IDX_W-1:0] ar_idx;
    logic             aw_full, w_full;
    csr_wbeat_t       w_in, w_beat;
    logic             commit_c;

    logic             bvalid_q, bvalid_d;
    logic             rvalid_q, rvalid_d;
    logic             arready_q, arready_d;
    logic [31:0]      rdata_q, rdata_d;
    logic             start_q, start_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [CFG_W-1:0] cfg_q, cfg_d;
`ifdef CSR_IRQ_EN
    logic             irq_en_q, irq_en_d;
    logic             irq_q, irq_d;
`endif

    logic             wr_ctrl_c, wr_status_c, ar_fire_c;
    logic [31:0]      status_c, rd_word_c;

    // Byte offset bits and protection attributes carry no meaning here
    logic unused_ok;
    assign unused_ok = ^{S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0],
                         S_AXI_AWPROT, S_AXI_ARPROT};

    assign w_in   = '{data: S_AXI_WDATA, strb: S_AXI_WSTRB};
    assign ar_idx = S_AXI_ARADDR[ADDR_W-1:2];

    csr_wr_holder #(.DATA_W(IDX_W)) u_aw_holder (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (S_AXI_AWVALID),
        .in_ready  (S_AXI_AWREADY),
        .in_data   (S_AXI_AWADDR[ADDR_W-1:2]),
        .clr       (commit_c),
        .out_valid (aw_full),
        .out_data  (aw_idx)
    );

    csr_wr_holder #(.DATA_W(WBEAT_W)) u_w_holder (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (S_AXI_WVALID),
        .in_ready  (S_AXI_WREADY),
        .in_data   (w_in),
        .clr       (commit_c),
        .out_valid (w_full),
        .out_data  (w_beat)
    );

    // Commit only when both halves are parked and the B slot is free
    assign commit_c    = aw_full && w_full && !bvalid_q;
    assign wr_ctrl_c   = commit_c && (aw_idx == IDX_W'(CSR_CTRL_IDX));
    assign wr_status_c = commit_c && (aw_idx == IDX_W'(CSR_STATUS_IDX));
    assign ar_fire_c   = S_AXI_ARVALID && arready_q;

    // Readable STATUS image
    always_comb begin
        status_c                  = '0;
        status_c[STATUS_BUSY_BIT] = busy_q;
        status_c[STATUS_DONE_BIT] = done_q;
`ifdef CSR_IRQ_EN
        status_c[STATUS_IRQ_EN_BIT] = irq_en_q;
`endif
    end

    // Read mux over current register state, so a same-cycle commit is not seen
    always_comb begin
        rd_word_c = '0;
        if (ar_idx == IDX_W'(CSR_STATUS_IDX)) begin
            rd_word_c = status_c;
        end
        for (int unsigned k = CSR_CFG_BASE_IDX; k < CSR_REG_NUM; k++) begin
            if (ar_idx == IDX_W'(k)) begin
                rd_word_c = cfg_q[CSR_DATA_W*(k-CSR_CFG_BASE_IDX) +: CSR_DATA_W];
            end
        end
    end

    // Next-state for write path, control/status and read channel
    always_comb begin
        cfg_d     = cfg_q;
        start_d   = 1'b0;
        busy_d    = busy_q;
        done_d    = done_q;
        bvalid_d  = bvalid_q;
        rvalid_d  = rvalid_q;
        rdata_d   = rdata_q;
`ifdef CSR_IRQ_EN
        irq_en_d  = irq_en_q;
        irq_d     = done_q && irq_en_q;
`endif

        for (int unsigned k = CSR_CFG_BASE_IDX; k < CSR_REG_NUM; k++) begin
            if (commit_c && (aw_idx == IDX_W'(k))) begin
                cfg_d[CSR_DATA_W*(k-CSR_CFG_BASE_IDX) +: CSR_DATA_W] =
                    apply_wstrb(cfg_q[CSR_DATA_W*(k-CSR_CFG_BASE_IDX) +: CSR_DATA_W],
                                w_beat.data, w_beat.strb);
            end
        end

        // START is dropped while a previous run is still busy
        if (wr_ctrl_c && w_beat.strb[0] && w_beat.data[CTRL_START_BIT] && !busy_q) begin
            start_d = 1'b1;
        end

        if (start_d) begin
            busy_d = 1'b1;
        end else if (done) begin
            busy_d = 1'b0;
        end

        // Clear first so a coinciding done pulse wins
        if (wr_status_c && w_beat.strb[0] && w_beat.data[STATUS_DONE_BIT]) begin
            done_d = 1'b0;
        end
        if (done) begin
            done_d = 1'b1;
        end

`ifdef CSR_IRQ_EN
        if (wr_status_c && w_beat.strb[0]) begin
            irq_en_d = w_beat.data[STATUS_IRQ_EN_BIT];
        end
`endif

        if (commit_c) begin
            bvalid_d = 1'b1;
        end else if (bvalid_q && S_AXI_BREADY) begin
            bvalid_d = 1'b0;
        end

        if (ar_fire_c) begin
            rvalid_d = 1'b1;
            rdata_d  = rd_word_c;
        end else if (rvalid_q && S_AXI_RREADY) begin
            rvalid_d = 1'b0;
        end
        arready_d = !rvalid_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cfg_q     <= '0;
            start_q   <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            bvalid_q  <= 1'b0;
            rvalid_q  <= 1'b0;
            arready_q <= 1'b0;
            rdata_q   <= '0;
`ifdef CSR_IRQ_EN
            irq_en_q  <= 1'b0;
            irq_q     <= 1'b0;
`endif
        end else begin
            cfg_q     <= cfg_d;
            start_q   <= start_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            bvalid_q  <= bvalid_d;
            rvalid_q  <= rvalid_d;
            arready_q <= arready_d;
            rdata_q   <= rdata_d;
`ifdef CSR_IRQ_EN
            irq_en_q  <= irq_en_d;
            irq_q     <= irq_d;
`endif
        end
    end

    assign S_AXI_BRESP   = AXI_RESP_OKAY;
    assign S_AXI_BVALID  = bvalid_q;
    assign S_AXI_ARREADY = arready_q;
    assign S_AXI_RDATA   = rdata_q;
    assign S_AXI_RRESP   = AXI_RESP_OKAY;
    assign S_AXI_RVALID  = rvalid_q;
    assign start         = start_q;
    assign csr_cfg       = cfg_q;
`ifdef CSR_IRQ_EN
    assign irq           = irq_q;
`endif

endmodule
